debounce_edge_detect: RTL and testbench

- Downstream consumer of the D flip-flop stage: takes its registered Q (raw, possibly glitchy, asynchronous to this domain) as input D.
- Synchronises D through two flops, then commits a new level only after STABLE_CYCLES consecutive enabled samples disagree with the current output.
- Emits a debounced level plus one-cycle Rise/Fall pulses for edge-triggered logic further down.

---
 rtl/debounce_edge_detect_pkg.sv | 14 +
 rtl/debounce_edge_detect_sync_2ff.sv | 24 ++
 rtl/debounce_edge_detect.sv | 96 +++++++++
 tb/tb_debounce_edge_detect.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared state encoding and parameter legality helper for the debouncer.
package debounce_edge_detect_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
    function automatic bit cnt_w_legal(input int stable_cycles, input int cnt_w);
        return (stable_cycles >= 2) && ((1 << cnt_w) > stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_edge_detect_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous raw level into the clk_i domain.
module sync_2ff (
    input  logic clk_i,
    input  logic clr_i,
    input  logic async_i,
    output logic sync_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
        end
    end

    assign sync_o = s2_q;

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronised level and emits one-cycle rise/fall pulses on each commit.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    input  logic en_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    if (!cnt_w_legal(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "debounce_edge_detect: CNT_W too narrow for STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             d_sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_2ff u_sync (
        .clk_i   (clk_i),
        .clr_i   (clr_i),
        .async_i (d_i),
        .sync_o  (d_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (en_i && (d_sync != q_q)) begin
                    state_d = ST_PENDING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (en_i) begin
                    if (d_sync == q_q) begin
                        // Level bounced back before it was trusted: drop silently.
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        q_d     = d_sync;
                        rise_d  = d_sync;
                        fall_d  = ~d_sync;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (state_q == ST_PENDING);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Scoreboard bench for debounce_edge_detect: a behavioural model queues expected outputs per edge.
module tb_debounce_edge_detect;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic d   = 1'b0;
    logic en  = 1'b0;
    logic q, rise, fall, busy;
    logic q2, rise2, fall2, busy2;
    logic q7, rise7, fall7, busy7;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] sb[$];
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_pend = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    always #5 clk = ~clk;

    debounce_edge_detect #(.STABLE_CYCLES(SC), .CNT_W(3)) dut (
        .clk_i(clk), .clr_i(clr), .d_i(d), .en_i(en),
        .q_o(q), .rise_o(rise), .fall_o(fall), .busy_o(busy)
    );

    debounce_edge_detect #(.STABLE_CYCLES(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .clr_i(clr), .d_i(d), .en_i(en),
        .q_o(q2), .rise_o(rise2), .fall_o(fall2), .busy_o(busy2)
    );

    debounce_edge_detect #(.STABLE_CYCLES(7), .CNT_W(3)) dut7 (
        .clk_i(clk), .clr_i(clr), .d_i(d), .en_i(en),
        .q_o(q7), .rise_o(rise7), .fall_o(fall7), .busy_o(busy7)
    );

    function automatic logic [3:0] obs();
        return {q, rise, fall, busy};
    endfunction

    // Advance the model by one edge, queue its expectation, then apply the edge.
    task automatic drive(input logic d_v, input logic en_v, input logic clr_v);
        if (clr_v) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0; m_pend = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en_v) begin
                if (!m_pend) begin
                    if (m_s2 != m_q) begin m_pend = 1'b1; m_run = 1; end
                end else if (m_s2 == m_q) begin
                    m_pend = 1'b0; m_run = 0;
                end else if (m_run == SC - 1) begin
                    m_q = m_s2; m_rise = m_s2; m_fall = ~m_s2; m_pend = 1'b0; m_run = 0;
                end else begin
                    m_run++;
                end
            end
            m_s2 = m_s1;
            m_s1 = d_v;
        end
        sb.push_back({m_q, m_rise, m_fall, m_pend});
        d = d_v; en = en_v; clr = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        int nrise = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL reset_sb i=%0d got=%b want=%b", i, obs(), exp); end
            vectors++;
            if (obs() !== 4'b0000) begin errors++; $display("FAIL reset_zero i=%0d got=%b want=0000", i, obs()); end
        end
        for (int e = 0; e < 8; e++) begin
            drive(1'b1, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL reset_rel_sb e=%0d got=%b want=%b", e, obs(), exp); end
            if (rise) nrise++;
            vectors++;
            if (q !== (e >= 5)) begin errors++; $display("FAIL reset_rel_q e=%0d got=%b want=%b", e, q, (e >= 5)); end
        end
        vectors++;
        if (nrise !== 1) begin errors++; $display("FAIL reset_rel_rise_count got=%0d want=1", nrise); end
    endtask

    task automatic test_clean_step();
        logic [3:0] exp;
        logic [3:0] want;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL step_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        for (int e = 0; e < 10; e++) begin
            drive(1'b1, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL step_up_sb e=%0d got=%b want=%b", e, obs(), exp); end
            want = {(e >= 5), (e == 5), 1'b0, (e >= 2 && e <= 4)};
            vectors++;
            if (obs() !== want) begin errors++; $display("FAIL step_up e=%0d got=%b want=%b", e, obs(), want); end
        end
        for (int e = 0; e < 10; e++) begin
            drive(1'b0, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL step_dn_sb e=%0d got=%b want=%b", e, obs(), exp); end
            want = {(e < 5), 1'b0, (e == 5), (e >= 2 && e <= 4)};
            vectors++;
            if (obs() !== want) begin errors++; $display("FAIL step_dn e=%0d got=%b want=%b", e, obs(), want); end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        int nrise = 0;
        int saw_busy = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL glitch_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        for (int e = 0; e < 11; e++) begin
            drive(e < 3, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL glitch3_sb e=%0d got=%b want=%b", e, obs(), exp); end
            if (busy) saw_busy++;
            if (rise) nrise++;
            vectors++;
            if (q !== 1'b0) begin errors++; $display("FAIL glitch3_q e=%0d got=%b want=0", e, q); end
        end
        vectors++;
        if (saw_busy != 3 || nrise != 0) begin
            errors++; $display("FAIL glitch3_busy_rise got busy=%0d rise=%0d want busy=3 rise=0", saw_busy, nrise);
        end
        for (int e = 0; e < 12; e++) begin
            drive(e < 4, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL glitch4_sb e=%0d got=%b want=%b", e, obs(), exp); end
            vectors++;
            if (q !== (e >= 5 && e <= 8)) begin
                errors++; $display("FAIL glitch4_q e=%0d got=%b want=%b", e, q, (e >= 5 && e <= 8));
            end
        end
    endtask

    task automatic test_en_gating();
        logic [3:0] exp;
        logic [2:0] prev_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL en_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        prev_cnt = dut.cnt_q;
        for (int e = 0; e < 12; e++) begin
            drive(1'b1, (e % 2) == 1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL en_sb e=%0d got=%b want=%b", e, obs(), exp); end
            vectors++;
            if (q !== (e >= 9)) begin errors++; $display("FAIL en_q e=%0d got=%b want=%b", e, q, (e >= 9)); end
            if ((e % 2) == 0) begin
                vectors++;
                if (dut.cnt_q !== prev_cnt) begin
                    errors++; $display("FAIL en_cnt_hold e=%0d got=%0d want=%0d", e, dut.cnt_q, prev_cnt);
                end
            end
            prev_cnt = dut.cnt_q;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        int npulse = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL mid_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL mid_run_sb e=%0d got=%b want=%b", e, obs(), exp); end
        end
        vectors++;
        if (dut.cnt_q !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pending got cnt=%0d busy=%b want cnt=2 busy=1", dut.cnt_q, busy);
        end
        drive(1'b1, 1'b1, 1'b1);
        exp = sb.pop_front(); vectors++;
        if (obs() !== exp) begin errors++; $display("FAIL mid_clr_sb got=%b want=%b", obs(), exp); end
        vectors++;
        if (obs() !== 4'b0000 || dut.cnt_q !== 3'd0) begin
            errors++; $display("FAIL mid_clr got=%b cnt=%0d want=0000 cnt=0", obs(), dut.cnt_q);
        end
        for (int e = 0; e < 8; e++) begin
            drive(1'b0, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL mid_post_sb e=%0d got=%b want=%b", e, obs(), exp); end
            if (rise || fall) npulse++;
        end
        vectors++;
        if (npulse !== 0) begin errors++; $display("FAIL mid_no_pulse got=%0d want=0", npulse); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int nrise = 0;
        int nfall = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL b2b_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        for (int e = 0; e < 24; e++) begin
            drive(((e / 4) % 2) == 0, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL b2b_sb e=%0d got=%b want=%b", e, obs(), exp); end
            vectors++;
            if (rise && fall) begin errors++; $display("FAIL b2b_excl e=%0d got rise=1 fall=1 want not both", e); end
            if (rise) nrise++;
            if (fall) nfall++;
        end
        vectors++;
        if (nrise !== 3 || nfall !== 2) begin
            errors++; $display("FAIL b2b_counts got rise=%0d fall=%0d want rise=3 fall=2", nrise, nfall);
        end
    endtask

    task automatic test_param_sweep();
        logic [3:0] exp;
        int first2 = -1;
        int first7 = -1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i == 0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL sweep_pre_sb i=%0d got=%b want=%b", i, obs(), exp); end
        end
        for (int e = 0; e < 12; e++) begin
            drive(1'b1, 1'b1, 1'b0);
            exp = sb.pop_front(); vectors++;
            if (obs() !== exp) begin errors++; $display("FAIL sweep_sb e=%0d got=%b want=%b", e, obs(), exp); end
            if (q2 === 1'b1 && first2 < 0) first2 = e;
            if (q7 === 1'b1 && first7 < 0) first7 = e;
        end
        vectors++;
        if (first2 !== 3) begin errors++; $display("FAIL sweep_sc2_latency got=%0d want=3", first2); end
        vectors++;
        if (first7 !== 8) begin errors++; $display("FAIL sweep_sc7_latency got=%0d want=8", first7); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_en_gating();
        test_reset_mid();
        test_back_to_back();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
